// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : ID/EX stage that decodes MIPS instructions into ALU controls and
//            operands, registered behind a valid/ready handshake with flush.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int         DATA_W       = 32,
    parameter logic [4:0] ILLEGAL_CTRL = 5'b11111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [4:0]        ex_alu_ctrl,
    output logic              ex_sign,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic              ex_wr_en,
    output logic [4:0]        ex_wr_reg,
    output logic              ex_ovf_chk,
    output logic              ex_illegal
);
    localparam logic [4:0] c_ALU_AND = 5'b00000;
    localparam logic [4:0] c_ALU_OR  = 5'b00001;
    localparam logic [4:0] c_ALU_ADD = 5'b00010;
    localparam logic [4:0] c_ALU_SUB = 5'b00110;
    localparam logic [4:0] c_ALU_SLT = 5'b00111;
    localparam logic [4:0] c_ALU_NOR = 5'b01100;
    localparam logic [4:0] c_ALU_XOR = 5'b01101;
    localparam logic [4:0] c_ALU_SLL = 5'b10000;
    localparam logic [4:0] c_ALU_SRL = 5'b10001;
    localparam logic [4:0] c_ALU_SRA = 5'b10010;

    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_zimm;
    logic [DATA_W-1:0] w_shamt_in1;
    logic [DATA_W-1:0] w_shvar_in1;
    logic [DATA_W-1:0] w_lui_in1;
    logic              w_unused_rs_field;

    assign w_op        = id_instr[31:26];
    assign w_fn        = id_instr[5:0];
    assign w_simm      = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
    assign w_zimm      = {{(DATA_W-16){1'b0}}, id_instr[15:0]};
    // The ALU takes its shift amount from In1[10:6].
    assign w_shamt_in1 = {{(DATA_W-11){1'b0}}, id_instr[10:6], 6'b0};
    assign w_shvar_in1 = {{(DATA_W-11){1'b0}}, id_rs_data[4:0], 6'b0};
    assign w_lui_in1   = {{(DATA_W-11){1'b0}}, 5'd16, 6'b0};
    assign w_unused_rs_field = ^id_instr[25:21];

    logic [4:0]        w_ctrl;
    logic              w_sign;
    logic              w_ovf;
    logic              w_illegal;
    logic [DATA_W-1:0] w_in1;
    logic [DATA_W-1:0] w_in2;
    logic              w_writes;
    logic [4:0]        w_dest;
    logic              w_wr_en;
    logic [4:0]        w_wr_reg;

    always_comb begin
        w_ctrl    = ILLEGAL_CTRL;
        w_sign    = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        w_in1     = id_rs_data;
        w_in2     = id_rt_data;
        w_writes  = 1'b0;
        w_dest    = 5'd0;
        case (w_op)
            6'h00: begin
                w_writes = 1'b1;
                w_dest   = id_instr[15:11];
                case (w_fn)
                    6'h20: begin w_ctrl = c_ALU_ADD; w_sign = 1'b1; w_ovf = 1'b1; end
                    6'h21: w_ctrl = c_ALU_ADD;
                    6'h22: begin w_ctrl = c_ALU_SUB; w_ovf = 1'b1; end
                    6'h23: w_ctrl = c_ALU_SUB;
                    6'h24: w_ctrl = c_ALU_AND;
                    6'h25: w_ctrl = c_ALU_OR;
                    6'h26: w_ctrl = c_ALU_XOR;
                    6'h27: w_ctrl = c_ALU_NOR;
                    6'h2A: begin w_ctrl = c_ALU_SLT; w_sign = 1'b1; end
                    6'h2B: w_ctrl = c_ALU_SLT;
                    6'h00: begin w_ctrl = c_ALU_SLL; w_in1 = w_shamt_in1; end
                    6'h02: begin w_ctrl = c_ALU_SRL; w_in1 = w_shamt_in1; end
                    6'h03: begin w_ctrl = c_ALU_SRA; w_in1 = w_shamt_in1; end
                    6'h04: begin w_ctrl = c_ALU_SLL; w_in1 = w_shvar_in1; end
                    6'h06: begin w_ctrl = c_ALU_SRL; w_in1 = w_shvar_in1; end
                    6'h07: begin w_ctrl = c_ALU_SRA; w_in1 = w_shvar_in1; end
                    default: w_illegal = 1'b1;
                endcase
            end
            6'h08: begin w_ctrl = c_ALU_ADD; w_in2 = w_simm; w_ovf = 1'b1; end
            6'h09: begin w_ctrl = c_ALU_ADD; w_in2 = w_simm; end
            6'h0A: begin w_ctrl = c_ALU_SLT; w_in2 = w_simm; w_sign = 1'b1; end
            6'h0B: begin w_ctrl = c_ALU_SLT; w_in2 = w_simm; end
            6'h0C: begin w_ctrl = c_ALU_AND; w_in2 = w_zimm; end
            6'h0D: begin w_ctrl = c_ALU_OR;  w_in2 = w_zimm; end
            6'h0E: begin w_ctrl = c_ALU_XOR; w_in2 = w_zimm; end
            6'h0F: begin w_ctrl = c_ALU_SLL; w_in1 = w_lui_in1; w_in2 = w_zimm; end
            6'h23: begin w_ctrl = c_ALU_ADD; w_in2 = w_simm; end
            6'h2B: w_ctrl = c_ALU_ADD;
            6'h04, 6'h05: w_ctrl = c_ALU_SUB;
            default: w_illegal = 1'b1;
        endcase
        // I-type writers target rt; sw keeps the immediate but never writes.
        if (w_op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) begin
            w_writes = 1'b1;
            w_dest   = id_instr[20:16];
        end
        if (w_op == 6'h2B)
            w_in2 = w_simm;
        if (w_illegal) begin
            w_ctrl   = ILLEGAL_CTRL;
            w_sign   = 1'b0;
            w_ovf    = 1'b0;
            w_in1    = '0;
            w_in2    = '0;
            w_writes = 1'b0;
            w_dest   = 5'd0;
        end
    end

    assign w_wr_en  = w_writes & (w_dest != 5'd0);
    assign w_wr_reg = w_wr_en ? w_dest : 5'd0;

    logic w_load;
    assign id_ready = ~ex_valid | ex_ready;
    assign w_load   = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_alu_ctrl <= 5'd0;
            ex_sign     <= 1'b0;
            ex_in1      <= '0;
            ex_in2      <= '0;
            ex_rt_data  <= '0;
            ex_wr_en    <= 1'b0;
            ex_wr_reg   <= 5'd0;
            ex_ovf_chk  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (w_load) begin
            ex_valid    <= 1'b1;
            ex_alu_ctrl <= w_ctrl;
            ex_sign     <= w_sign;
            ex_in1      <= w_in1;
            ex_in2      <= w_in2;
            ex_rt_data  <= id_rt_data;
            ex_wr_en    <= w_wr_en;
            ex_wr_reg   <= w_wr_reg;
            ex_ovf_chk  <= w_ovf;
            ex_illegal  <= w_illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the execute-stage ALU.
- Decodes a MIPS instruction into the ALU's 5-bit operation code, Sign flag and two operands.
- Registers the result behind a valid/ready handshake, with stall and flush support.
- Owns all operand-placement rules the ALU relies on, notably that shift amounts are carried in In1[10:6].

Parameters:
- DATA_W, 32, operand/register width (fixed by the ALU; other values unsupported)
- ILLEGAL_CTRL, 5'b11111, operation code issued for undecodable instructions (ALU returns 0)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  stage can accept this cycle
- id_instr  in  32  instruction word
- id_rs_data  in  32  rs value, already forwarded
- id_rt_data  in  32  rt value, already forwarded
- flush  in  1  squash held/incoming instruction (branch/exception)
- ex_ready  in  1  execute stage consumes ex_* this cycle
- ex_valid  out  1  ex_* outputs hold a live instruction
- ex_alu_ctrl  out  5  ALU operation code
- ex_sign  out  1  signed compare select
- ex_in1  out  32  ALU operand 1
- ex_in2  out  32  ALU operand 2
- ex_rt_data  out  32  store data (rt)
- ex_wr_en  out  1  instruction writes a register
- ex_wr_reg  out  5  destination register
- ex_ovf_chk  out  1  add/addi/sub: trap on signed overflow
- ex_illegal  out  1  reserved-instruction flag

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output is 0, including ex_valid. id_ready is therefore 1 one combinational path after release.
- id_ready = ~ex_valid | ex_ready (combinational; no bubble on a continuous stream).
- Load condition: id_valid & id_ready & ~flush.
  - Load captures the decoded fields and sets ex_valid=1.
  - Latency: exactly one cycle from id accept to ex_* visible.
- Hold: ex_valid & ~ex_ready & ~flush keeps all ex_* bit-stable.
- Drain: ex_ready with no load clears ex_valid. Payload fields may keep stale values.
- Flush (synchronous, highest priority): next cycle ex_valid=0 regardless of id_valid/ex_ready. The flushed-cycle id instruction is dropped.
- R-type (opcode 0): In1=rs, In2=rt, wr_reg=rd, wr_en=1. Decode by funct:
  - 0x20 add: 00010, sign=1, ovf=1
  - 0x21 addu: 00010, sign=0
  - 0x22 sub: 00110, ovf=1
  - 0x23 subu: 00110
  - 0x24 and: 00000
  - 0x25 or: 00001
  - 0x26 xor: 01101
  - 0x27 nor: 01100
  - 0x2A slt: 00111, sign=1
  - 0x2B sltu: 00111, sign=0
- R-type shifts (In2=rt):
  - 0x00 sll 10000, 0x02 srl 10001, 0x03 sra 10010: In1={21'b0, instr[10:6], 6'b0}.
  - 0x04 sllv, 0x06 srlv, 0x07 srav (same codes): In1={21'b0, rs[4:0], 6'b0}.
- I-type: In1=rs, wr_reg=rt, wr_en=1. Decode by opcode:
  - 0x08 addi: 00010, sign-extended immediate, ovf=1
  - 0x09 addiu: 00010, sign-extended immediate
  - 0x0A slti: 00111, sign=1, sign-extended immediate
  - 0x0B sltiu: 00111, sign=0, sign-extended immediate
  - 0x0C andi: 00000, zero-extended immediate
  - 0x0D ori: 00001, zero-extended immediate
  - 0x0E xori: 01101, zero-extended immediate
  - 0x0F lui: 10000, In1=32'h0000_0400 (shift 16), In2=zero-extended immediate
- Memory:
  - 0x23 lw: 00010, In2 = sign-extended immediate, wr_en=1.
  - 0x2B sw: 00010, In2 = sign-extended immediate, wr_en=0.
- Branch: 0x04 beq and 0x05 bne: 00110, In1=rs, In2=rt, wr_en=0.
- Destination register 0: wr_reg=0 forces wr_en=0.
- Any other opcode/funct:
  - Outputs: alu_ctrl=ILLEGAL_CTRL, illegal=1, wr_en=0, ovf=0.
  - The instruction still flows with ex_valid=1.
- Unlisted output fields are 0 (sign=0, ovf=0).
- Reset asserted mid-stall drops the held instruction; no partial state survives.

Test Plan:
- Reset then release, id_valid=0 → ex_valid=0, all ex_*=0, id_ready=1.
- Inputs: addi $5,$3,-4 (0x2065FFFC), rs=7, ex_ready=1 → next cycle: ex_alu_ctrl=00010, in1=7, in2=0xFFFFFFFC, wr_reg=5, wr_en=1, ovf_chk=1.
- Operand placement:
  - sra $2,$4,3 (0x000410C3), rt=0x80000000 → ctrl=10010, in1=0x000000C0, in2=0x80000000.
  - lui $1,0x1234 → ctrl=10000, in1=0x400, in2=0x00001234.
- Stall: load sltu, hold ex_ready=0 for 3 cycles while id_valid=1 with a new instr → ex_* unchanged and id_ready=0 throughout. ex_ready=1 → new instr appears the next cycle.
- Flush priority: flush=1 with id_valid=1, ex_ready=1 → next cycle ex_valid=0. Flush during a stall also clears ex_valid.
- Illegal case: opcode 0x3F → ex_valid=1, ex_illegal=1, ctrl=11111, wr_en=0. Also addu to $0 → wr_en=0.
